// File: rtl/uart_sim_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : uart_sim_rx_monitor
// Brief    : 8N1 UART receiver that recovers bytes from the uart0 TX line,
//            counts them and flags the ASCII strings "PASS" and "FAIL".
// Revision : 1.0 - initial release
// ============================================================================
module uart_sim_rx_monitor #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD_RATE      = 1_500_000,
  parameter int CYCLES_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        enable_i,
  input  logic        rx_i,
  output logic        byte_valid_o,
  output logic [7:0]  byte_o,
  output logic        frame_err_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic [31:0] byte_count_o
);

  localparam int c_HALF_BIT = CYCLES_PER_BIT / 2;
  localparam int c_CNT_W    = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [c_CNT_W-1:0] c_BIT_LAST  = c_CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(c_HALF_BIT - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  generate
    if (CYCLES_PER_BIT < 4) begin : g_param_check
      $error("uart_sim_rx_monitor: CYCLES_PER_BIT must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t             r_state;
  logic               r_rx_meta;
  logic               r_rx_s;
  logic [c_CNT_W-1:0] r_cnt;
  logic [2:0]         r_bit_idx;
  logic [7:0]         r_shift;
  logic               r_byte_valid;
  logic [7:0]         r_byte;
  logic               r_frame_err;
  logic [31:0]        r_byte_count;
  logic [2:0]         r_pass_idx;
  logic [2:0]         r_fail_idx;
  logic               r_pass;
  logic               r_fail;
  logic               w_cnt_bit_done;

  assign w_cnt_bit_done = (r_cnt == c_BIT_LAST);

  // The line is asynchronous; idle-high reset avoids a false start after reset.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'h00;
      r_byte_valid <= 1'b0;
      r_byte       <= 8'h00;
      r_frame_err  <= 1'b0;
      r_byte_count <= 32'd0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      if (!enable_i) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (!r_rx_s) begin
              r_state <= S_START;
              r_cnt   <= '0;
            end
          end
          S_START: begin
            if (r_cnt == c_HALF_LAST) begin
              r_state   <= r_rx_s ? S_IDLE : S_DATA;
              r_cnt     <= '0;
              r_bit_idx <= 3'd0;
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end
          S_DATA: begin
            if (w_cnt_bit_done) begin
              // LSB arrives first, so shifting in at the top leaves it at bit 0.
              r_shift   <= {r_rx_s, r_shift[7:1]};
              r_cnt     <= '0;
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) begin
                r_state <= S_STOP;
              end
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end
          S_STOP: begin
            if (w_cnt_bit_done) begin
              r_cnt <= '0;
              if (r_rx_s) begin
                r_byte       <= r_shift;
                r_byte_valid <= 1'b1;
                r_byte_count <= r_byte_count + 32'd1;
                r_state      <= S_IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= S_BREAK;
              end
            end else begin
              r_cnt <= r_cnt + c_CNT_ONE;
            end
          end
          S_BREAK: begin
            if (r_rx_s) begin
              r_state <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  function automatic logic [7:0] f_pass_char(input logic [2:0] idx);
    case (idx)
      3'd0:    f_pass_char = 8'h50;
      3'd1:    f_pass_char = 8'h41;
      default: f_pass_char = 8'h53;
    endcase
  endfunction

  function automatic logic [7:0] f_fail_char(input logic [2:0] idx);
    case (idx)
      3'd0:    f_fail_char = 8'h46;
      3'd1:    f_fail_char = 8'h41;
      3'd2:    f_fail_char = 8'h49;
      default: f_fail_char = 8'h4C;
    endcase
  endfunction

  // Matchers consume the registered byte, so flags trail byte_valid_o by one cycle.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      r_pass_idx <= 3'd0;
      r_fail_idx <= 3'd0;
      r_pass     <= 1'b0;
      r_fail     <= 1'b0;
    end else if (r_byte_valid) begin
      if (r_byte == f_pass_char(r_pass_idx)) begin
        if (r_pass_idx == 3'd3) begin
          r_pass     <= 1'b1;
          r_pass_idx <= 3'd0;
        end else begin
          r_pass_idx <= r_pass_idx + 3'd1;
        end
      end else begin
        r_pass_idx <= (r_byte == 8'h50) ? 3'd1 : 3'd0;
      end
      if (r_byte == f_fail_char(r_fail_idx)) begin
        if (r_fail_idx == 3'd3) begin
          r_fail     <= 1'b1;
          r_fail_idx <= 3'd0;
        end else begin
          r_fail_idx <= r_fail_idx + 3'd1;
        end
      end else begin
        r_fail_idx <= (r_byte == 8'h46) ? 3'd1 : 3'd0;
      end
    end
  end

  assign byte_valid_o = r_byte_valid;
  assign byte_o       = r_byte;
  assign frame_err_o  = r_frame_err;
  assign pass_o       = r_pass;
  assign fail_o       = r_fail;
  assign byte_count_o = r_byte_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_sim_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_sim_rx_monitor
// Brief    : Directed self-checking bench for uart_sim_rx_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_sim_rx_monitor;

  localparam int c_CPB = 33;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        enable_i = 1'b1;
  logic        rx_i = 1'b1;
  logic        byte_valid_o;
  logic [7:0]  byte_o;
  logic        frame_err_o;
  logic        pass_o;
  logic        fail_o;
  logic [31:0] byte_count_o;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n_strobe = 0;
  int n_ferr = 0;
  bit pend = 1'b0;
  logic [7:0] rx_bytes[$];
  bit         pass_at[$];
  bit         pass_next[$];
  int         strobe_cyc[$];

  uart_sim_rx_monitor dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .enable_i     (enable_i),
    .rx_i         (rx_i),
    .byte_valid_o (byte_valid_o),
    .byte_o       (byte_o),
    .frame_err_o  (frame_err_o),
    .pass_o       (pass_o),
    .fail_o       (fail_o),
    .byte_count_o (byte_count_o)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cyc <= cyc + 1;

  // Passive observer: logs every strobe and the pass flag at and after it.
  always @(negedge clk_sys) begin
    if (pend) begin
      pass_next.push_back(pass_o);
      pend = 1'b0;
    end
    if (byte_valid_o) begin
      rx_bytes.push_back(byte_o);
      pass_at.push_back(pass_o);
      strobe_cyc.push_back(cyc);
      n_strobe = n_strobe + 1;
      pend = 1'b1;
    end
    if (frame_err_o) n_ferr = n_ferr + 1;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    idle(c_CPB);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      idle(c_CPB);
    end
    rx_i = stop_bit;
    idle(c_CPB);
  endtask

  task automatic apply_reset();
    rst_sys_n = 1'b0;
    rx_i = 1'b1;
    enable_i = 1'b1;
    idle(3);
    rst_sys_n = 1'b1;
    idle(5);
  endtask

  task automatic test_reset();
    rst_sys_n = 1'b0;
    rx_i = 1'b1;
    idle(3);
    total++; if (byte_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", byte_valid_o); end
    total++; if (byte_o !== 8'h00) begin bad++; $display("FAIL reset_byte: got %h want 00", byte_o); end
    total++; if (frame_err_o !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
    total++; if (pass_o !== 1'b0 || fail_o !== 1'b0) begin bad++; $display("FAIL reset_flags: got %b%b want 00", pass_o, fail_o); end
    total++; if (byte_count_o !== 32'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", byte_count_o); end
    rst_sys_n = 1'b1;
    idle(5);
  endtask

  task automatic test_single();
    int base_s, base_f, t0;
    apply_reset();
    base_s = n_strobe; base_f = n_ferr;
    t0 = cyc;
    send_byte(8'h55, 1'b1);
    idle(20);
    total++; if (n_strobe - base_s !== 1) begin bad++; $display("FAIL single_strobes: got %0d want 1", n_strobe - base_s); end
    if (n_strobe > base_s) begin
      // 2 synchronizer cycles plus 314 cycles from synchronized start detect.
      total++; if (strobe_cyc[base_s] - t0 !== 316) begin bad++; $display("FAIL single_latency: got %0d want 316", strobe_cyc[base_s] - t0); end
      total++; if (rx_bytes[base_s] !== 8'h55) begin bad++; $display("FAIL single_byte: got %h want 55", rx_bytes[base_s]); end
    end
    total++; if (byte_count_o !== 32'd1) begin bad++; $display("FAIL single_count: got %0d want 1", byte_count_o); end
    total++; if (n_ferr - base_f !== 0) begin bad++; $display("FAIL single_ferr: got %0d want 0", n_ferr - base_f); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] msg[8];
    int base_s;
    msg = '{8'h78, 8'h50, 8'h41, 8'h50, 8'h41, 8'h53, 8'h53, 8'h0A};
    apply_reset();
    base_s = n_strobe;
    for (int i = 0; i < 8; i++) send_byte(msg[i], 1'b1);
    idle(20);
    total++; if (n_strobe - base_s !== 8) begin bad++; $display("FAIL b2b_strobes: got %0d want 8", n_strobe - base_s); end
    if (n_strobe - base_s == 8) begin
      for (int i = 0; i < 8; i++) begin
        total++; if (rx_bytes[base_s + i] !== msg[i]) begin bad++; $display("FAIL b2b_byte%0d: got %h want %h", i, rx_bytes[base_s + i], msg[i]); end
      end
      total++; if (pass_next[base_s + 5] !== 1'b0) begin bad++; $display("FAIL b2b_pass_early: got %b want 0", pass_next[base_s + 5]); end
      total++; if (pass_at[base_s + 6] !== 1'b0) begin bad++; $display("FAIL b2b_pass_at_strobe: got %b want 0", pass_at[base_s + 6]); end
      total++; if (pass_next[base_s + 6] !== 1'b1) begin bad++; $display("FAIL b2b_pass_after7: got %b want 1", pass_next[base_s + 6]); end
    end
    total++; if (fail_o !== 1'b0) begin bad++; $display("FAIL b2b_fail: got %b want 0", fail_o); end
    total++; if (byte_count_o !== 32'd8) begin bad++; $display("FAIL b2b_count: got %0d want 8", byte_count_o); end
  endtask

  task automatic test_glitch();
    int base_s, base_f;
    apply_reset();
    base_s = n_strobe; base_f = n_ferr;
    rx_i = 1'b0;
    idle(10);
    rx_i = 1'b1;
    idle(400);
    total++; if (n_strobe - base_s !== 0) begin bad++; $display("FAIL glitch_strobes: got %0d want 0", n_strobe - base_s); end
    total++; if (n_ferr - base_f !== 0) begin bad++; $display("FAIL glitch_ferr: got %0d want 0", n_ferr - base_f); end
    send_byte(8'h5A, 1'b1);
    idle(20);
    total++; if (byte_o !== 8'h5A || n_strobe - base_s !== 1) begin bad++; $display("FAIL glitch_recover: got %h/%0d want 5a/1", byte_o, n_strobe - base_s); end
  endtask

  task automatic test_break();
    int base_s, base_f;
    apply_reset();
    base_s = n_strobe; base_f = n_ferr;
    send_byte(8'hA3, 1'b0);
    idle(1000);
    rx_i = 1'b1;
    idle(40);
    total++; if (n_ferr - base_f !== 1) begin bad++; $display("FAIL break_ferr: got %0d want 1", n_ferr - base_f); end
    total++; if (n_strobe - base_s !== 0) begin bad++; $display("FAIL break_strobes: got %0d want 0", n_strobe - base_s); end
    total++; if (byte_count_o !== 32'd0) begin bad++; $display("FAIL break_count: got %0d want 0", byte_count_o); end
    send_byte(8'h41, 1'b1);
    idle(20);
    total++; if (byte_o !== 8'h41) begin bad++; $display("FAIL break_next_byte: got %h want 41", byte_o); end
    total++; if (byte_count_o !== 32'd1) begin bad++; $display("FAIL break_next_count: got %0d want 1", byte_count_o); end
  endtask

  task automatic test_enable();
    logic [7:0] msg[4];
    int base_s;
    msg = '{8'h46, 8'h41, 8'h49, 8'h4C};
    apply_reset();
    base_s = n_strobe;
    // Start bit then all-ones data; without the abort this would decode 0xFF.
    rx_i = 1'b0;
    idle(c_CPB);
    rx_i = 1'b1;
    idle(150 - c_CPB);
    enable_i = 1'b0;
    idle(50);
    enable_i = 1'b1;
    idle(400);
    total++; if (n_strobe - base_s !== 0) begin bad++; $display("FAIL enable_abort_strobes: got %0d want 0", n_strobe - base_s); end
    for (int i = 0; i < 4; i++) send_byte(msg[i], 1'b1);
    idle(20);
    total++; if (fail_o !== 1'b1) begin bad++; $display("FAIL enable_fail_flag: got %b want 1", fail_o); end
    total++; if (pass_o !== 1'b0) begin bad++; $display("FAIL enable_pass_flag: got %b want 0", pass_o); end
    total++; if (byte_count_o !== 32'd4) begin bad++; $display("FAIL enable_count: got %0d want 4", byte_count_o); end
  endtask

  task automatic test_reset_mid_frame();
    apply_reset();
    send_byte(8'h50, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h53, 1'b1);
    idle(5);
    total++; if (byte_count_o !== 32'd3) begin bad++; $display("FAIL rmid_pre_count: got %0d want 3", byte_count_o); end
    rx_i = 1'b0;
    idle(c_CPB);
    rx_i = 1'b1;
    idle(67);
    rst_sys_n = 1'b0;
    #1;
    total++; if (byte_count_o !== 32'd0 || byte_o !== 8'h00 || pass_o !== 1'b0) begin bad++; $display("FAIL rmid_reset_outputs: got %0d/%h/%b want 0/00/0", byte_count_o, byte_o, pass_o); end
    idle(3);
    rst_sys_n = 1'b1;
    idle(400);
    send_byte(8'h53, 1'b1);
    idle(20);
    total++; if (pass_o !== 1'b0) begin bad++; $display("FAIL rmid_pass_after_S: got %b want 0", pass_o); end
    total++; if (byte_count_o !== 32'd1 || byte_o !== 8'h53) begin bad++; $display("FAIL rmid_next: got %0d/%h want 1/53", byte_count_o, byte_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_enable();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
